// File: rtl/dmem_lane.sv
// ----------------------------------------------------------------------------
// dmem_lane
//
// Word-organised data RAM for the load/store unit. Stores write little-endian
// byte lanes, loads extract a byte, half or word lane and sign- or
// zero-extend it. Requests use a valid/ready port. Each accepted request gets
// a registered one-cycle response. Misaligned accesses and the reserved size
// fault and leave the array untouched. After reset a clear sequencer zeroes
// every word before the port opens.
//
// Handshake: a request is taken on a rising edge when req_valid && req_ready.
// req_ready depends only on the FSM state (0 while clearing, 1 when running),
// so it never has a combinational dependency on req_*. The response
// (rsp_valid/rsp_rdata/rsp_fault) is valid for exactly the one cycle after
// the accepting edge. At all other times rsp_rdata and rsp_fault are 0.
//
// Parameters
//   DEPTH_LOG2  log2 of word count (DEPTH = 2**DEPTH_LOG2 32-bit words)
//   TRACE       1 = print one line per committed store (simulation only)
//
// Ports
//   clk           in   clock, all state updates on the rising edge
//   reset         in   synchronous, active-high
//   req_valid     in   request present
//   req_ready     out  request can be accepted this cycle
//   req_we        in   1 = store, 0 = load
//   req_size      in   00 word, 01 half, 10 byte, 11 reserved (faults)
//   req_unsigned  in   load extension: 1 = zero, 0 = sign
//   req_addr      in   byte address; word index = addr[DEPTH_LOG2+1:2]
//   req_wdata     in   right-aligned store data
//   rsp_valid     out  one-cycle pulse per accepted request
//   rsp_rdata     out  load result; 0 for stores and faults
//   rsp_fault     out  request was misaligned or used the reserved size
//   dbg_state     out  FSM state (0 = INIT/clearing, 1 = RUN)
// ----------------------------------------------------------------------------
module dmem_lane #(
   parameter int DEPTH_LOG2 = 10,
   parameter bit TRACE      = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault,
   output logic        dbg_state
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DEPTH_LOG2-1:0] r_clr_cnt;
   logic                  w_ready;

   logic [31:0]           r_mem [DEPTH];

   logic                  r_rsp_valid;
   logic [31:0]           r_rsp_rdata;
   logic                  r_rsp_fault;

   logic [DEPTH_LOG2-1:0] w_idx;
   logic [1:0]            w_off;
   logic [31:0]           w_word;
   logic                  w_accept;
   logic                  w_fault;
   logic                  w_wr_en;
   logic [3:0]            w_be;
   logic [31:0]           w_wlane;
   logic [31:0]           w_merged;
   logic [15:0]           w_half;
   logic [7:0]            w_byte;
   logic [31:0]           w_load;
   logic                  w_unused_addr;

   // -------------------------------------------------------------------------
   // FSM: INIT sweeps the clear counter over every word, RUN serves requests.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      case (r_state)
         ST_INIT: begin
            // The edge that clears the last word also opens the port.
            if (&r_clr_cnt) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_ready = 1'b1;
         end
         default: begin
            w_state_nxt = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_clr_cnt <= '0;
      end else if (r_state == ST_INIT) begin
         r_clr_cnt <= r_clr_cnt + 1'b1;
      end
   end

   assign req_ready = w_ready;
   assign dbg_state = logic'(r_state);

   // -------------------------------------------------------------------------
   // Request decode. Address bits above the word index are ignored, so
   // addresses alias every 4*DEPTH bytes.
   // -------------------------------------------------------------------------
   assign w_idx         = req_addr[DEPTH_LOG2+1:2];
   assign w_off         = req_addr[1:0];
   assign w_unused_addr = &{1'b0, req_addr[31:DEPTH_LOG2+2]};
   assign w_word        = r_mem[w_idx];
   assign w_accept      = req_valid && w_ready;

   always_comb begin
      w_fault = 1'b0;
      case (req_size)
         2'b00:   w_fault = (w_off != 2'b00);
         2'b01:   w_fault = w_off[0];
         2'b10:   w_fault = 1'b0;
         default: w_fault = 1'b1;
      endcase
   end

   assign w_wr_en = w_accept && req_we && !w_fault;

   // Store data is replicated across all lanes of its size, so the byte
   // enables alone select which copy lands in the word.
   always_comb begin
      w_be    = 4'b0000;
      w_wlane = '0;
      case (req_size)
         2'b00: begin
            w_be    = 4'b1111;
            w_wlane = req_wdata;
         end
         2'b01: begin
            w_be    = w_off[1] ? 4'b1100 : 4'b0011;
            w_wlane = {2{req_wdata[15:0]}};
         end
         2'b10: begin
            w_be    = 4'b0001 << w_off;
            w_wlane = {4{req_wdata[7:0]}};
         end
         default: begin
            w_be    = 4'b0000;
            w_wlane = '0;
         end
      endcase
   end

   always_comb begin
      w_merged = w_word;
      for (int k = 0; k < 4; k++) begin
         if (w_be[k]) begin
            w_merged[8*k +: 8] = w_wlane[8*k +: 8];
         end
      end
   end

   // Load lane extraction and extension.
   assign w_half = w_off[1] ? w_word[31:16] : w_word[15:0];

   always_comb begin
      w_byte = w_word[7:0];
      case (w_off)
         2'b00:   w_byte = w_word[7:0];
         2'b01:   w_byte = w_word[15:8];
         2'b10:   w_byte = w_word[23:16];
         default: w_byte = w_word[31:24];
      endcase
   end

   always_comb begin
      w_load = '0;
      case (req_size)
         2'b00:   w_load = w_word;
         2'b01:   w_load = {{16{!req_unsigned && w_half[15]}}, w_half};
         2'b10:   w_load = {{24{!req_unsigned && w_byte[7]}}, w_byte};
         default: w_load = '0;
      endcase
   end

   // -------------------------------------------------------------------------
   // Array: a single write port shared by the clear sweep and stores. Stores
   // only happen in RUN, so the two never collide.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (r_state == ST_INIT) begin
            r_mem[r_clr_cnt] <= '0;
         end else if (w_wr_en) begin
            r_mem[w_idx] <= w_merged;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Registered response. A store accepted at edge N is already in the array
   // when a load accepted at edge N+1 reads it, so no bypass is needed.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_fault <= 1'b0;
      end else begin
         r_rsp_valid <= w_accept;
         r_rsp_fault <= w_accept && w_fault;
         r_rsp_rdata <= (w_accept && !req_we && !w_fault) ? w_load : '0;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_fault = r_rsp_fault;

   generate
      if (TRACE) begin : g_trace
         always_ff @(posedge clk) begin
            if (!reset && w_wr_en) begin
               $display("dmem_lane store addr=%08h word=%08h", req_addr, w_merged);
            end
         end
      end
   endgenerate

endmodule
